// File: rtl/clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_pkg
// Description : Shared FSM state encoding and default parameters for
//               clk_reset_gen.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_pkg;

    typedef enum logic [1:0] {
        CLK_HOLD  = 2'd0,
        CLK_COUNT = 2'd1,
        CLK_RUN   = 2'd2
    } clk_state_e;

    localparam int unsigned CLK_LOCK_CYCLES_DEF = 1024;
    localparam int unsigned CLK_ACC_W_DEF       = 24;
    localparam int unsigned CLK_TICK_INC_DEF    = 1041211;

endpackage : clk_pkg
`default_nettype wire

// File: rtl/clk_reset_gen_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer, asynchronous active-high reset
//               clearing both stages to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_d, meta_q;
    logic [WIDTH-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clk_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_reset_gen
// Description : Lock-qualified reset generator plus phase-accumulator tick NCO.
//               Optional macro CLK_LOCK_LOSS_CNT_EN adds a saturating
//               lock-loss counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_reset_gen
    import clk_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = CLK_LOCK_CYCLES_DEF,
    parameter int unsigned ACC_W       = CLK_ACC_W_DEF,
    parameter int unsigned TICK_INC    = CLK_TICK_INC_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    output logic       rst_out,
    output logic       ready,
    output logic       tick
`ifdef CLK_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lock_loss_cnt
`endif
);

    localparam int unsigned        CNT_W      = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [ACC_W-1:0]   C_INC      = ACC_W'(TICK_INC);

    logic             lock_s;
    clk_state_e       state_d, state_q;
    logic [CNT_W-1:0] count_d, count_q;
    logic             rst_out_d, rst_out_q;
    logic             ready_d, ready_q;
    logic             tick_d, tick_q;
    logic [ACC_W-1:0] acc_d, acc_q;
    logic [ACC_W:0]   w_sum;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clock),
        .rst (reset),
        .i_d (locked),
        .o_q (lock_s)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= CLK_HOLD;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            CLK_HOLD: begin
                if (lock_s) state_d = CLK_COUNT;
            end
            CLK_COUNT: begin
                if (!lock_s)                  state_d = CLK_HOLD;
                else if (count_q == C_CNT_LAST) state_d = CLK_RUN;
                else                          count_d = count_q + 1'b1;
            end
            CLK_RUN: begin
                if (!lock_s) state_d = CLK_HOLD;
            end
            default: state_d = CLK_HOLD;
        endcase
    end

    // The entry edge into RUN leaves acc cleared; accumulation starts one
    // edge later, so tick phase is identical after every (re)lock.
    always_comb begin
        rst_out_d = (state_d != CLK_RUN);
        ready_d   = (state_d == CLK_RUN);
        w_sum     = {1'b0, acc_q} + {1'b0, C_INC};
        if ((state_q == CLK_RUN) && (state_d == CLK_RUN)) begin
            tick_d = w_sum[ACC_W];
            acc_d  = w_sum[ACC_W-1:0];
        end else begin
            tick_d = 1'b0;
            acc_d  = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_out_q <= 1'b1;
            ready_q   <= 1'b0;
            tick_q    <= 1'b0;
            acc_q     <= '0;
        end else begin
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            tick_q    <= tick_d;
            acc_q     <= acc_d;
        end
    end

    assign rst_out = rst_out_q;
    assign ready   = ready_q;
    assign tick    = tick_q;

`ifdef CLK_LOCK_LOSS_CNT_EN
    logic [7:0] loss_cnt_d, loss_cnt_q;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == CLK_RUN) && (state_d == CLK_HOLD) && (loss_cnt_q != 8'hFF))
            loss_cnt_d = loss_cnt_q + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) loss_cnt_q <= 8'd0;
        else       loss_cnt_q <= loss_cnt_d;
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

endmodule : clk_reset_gen
`default_nettype wire

// File: tb/tb_clk_reset_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_reset_gen
// Description : Directed self-checking bench for clk_reset_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_reset_gen;

    localparam int unsigned C_LC = 16;

    logic clock;
    logic reset;
    logic locked;
    logic rst_out_a, ready_a, tick_a;
    logic rst_out_b, ready_b, tick_b;
`ifdef CLK_LOCK_LOSS_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // dut_a: half-rate increment (alternating tick); dut_b: default increment
    clk_reset_gen #(.LOCK_CYCLES(C_LC), .ACC_W(24), .TICK_INC(32'd8388608)) dut_a (
        .clock         (clock),
        .reset         (reset),
        .locked        (locked),
        .rst_out       (rst_out_a),
        .ready         (ready_a),
        .tick          (tick_a)
`ifdef CLK_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (cnt_a)
`endif
    );

    clk_reset_gen #(.LOCK_CYCLES(C_LC), .ACC_W(24), .TICK_INC(1041211)) dut_b (
        .clock         (clock),
        .reset         (reset),
        .locked        (locked),
        .rst_out       (rst_out_b),
        .ready         (ready_b),
        .tick          (tick_b)
`ifdef CLK_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt (cnt_b)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic do_reset();
        @(negedge clock);
        reset  = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
    endtask

    // Raise locked at a negedge and follow edges E0..E(last), checking
    // reset release and the alternating tick pattern on dut_a.
    task automatic lock_and_check(input string tag, input int last);
        logic exp_rst, exp_tick;
        @(negedge clock);
        locked = 1'b1;
        for (int k = 0; k <= last; k++) begin
            @(posedge clock);
            #1;
            exp_rst = (k < C_LC + 2);
            n_checks++;
            if (rst_out_a !== exp_rst || ready_a !== !exp_rst) begin
                $display("FAIL %s rst E%0d: rst_out=%b ready=%b required rst_out=%b ready=%b",
                         tag, k, rst_out_a, ready_a, exp_rst, !exp_rst);
            end else n_pass++;
            if (k >= C_LC + 2) begin
                exp_tick = (k >= C_LC + 4) && (((k - (C_LC + 4)) % 2) == 0);
                n_checks++;
                if (tick_a !== exp_tick)
                    $display("FAIL %s tick E%0d: got %b required %b", tag, k, tick_a, exp_tick);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        reset  = 1'b1;
        locked = 1'b0;
        #1;
        n_checks++;
        if (rst_out_a !== 1'b1 || ready_a !== 1'b0 || tick_a !== 1'b0) begin
            $display("FAIL reset_state: rst_out=%b ready=%b tick=%b required 1 0 0",
                     rst_out_a, ready_a, tick_a);
        end else n_pass++;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            if (rst_out_a !== 1'b1 || ready_a !== 1'b0 || tick_a !== 1'b0 ||
                rst_out_b !== 1'b1 || tick_b !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL hold_unlocked: %0d bad cycles required 0", bad);
        else n_pass++;
    endtask

    task automatic test_release();
        do_reset();
        lock_and_check("release", C_LC + 2);
    endtask

    task automatic test_glitch();
        do_reset();
        @(negedge clock);
        locked = 1'b1;
        repeat (13) @(posedge clock);   // through E12: counter = 10
        @(negedge clock);
        locked = 1'b0;                  // sampled low at E13
        @(posedge clock);
        #1;
        n_checks++;
        if (rst_out_a !== 1'b1) $display("FAIL glitch_mid: rst_out=%b required 1", rst_out_a);
        else n_pass++;
        lock_and_check("glitch", C_LC + 2);
    endtask

    task automatic test_nco();
        int ticks = 0;
        do_reset();
        lock_and_check("nco", C_LC + 8);
        do_reset();
        @(negedge clock);
        locked = 1'b1;
        repeat (C_LC + 3) @(posedge clock);   // through E(LC+2): first RUN edge
        for (int i = 0; i < 24750; i++) begin
            @(posedge clock);
            #1;
            if (tick_b === 1'b1) ticks++;
        end
        n_checks++;
        if (ticks < 1535 || ticks > 1537)
            $display("FAIL nco_rate: ticks=%0d required 1536+-1", ticks);
        else n_pass++;
    endtask

    task automatic test_lock_loss();
        int wait_cnt;
        do_reset();
        lock_and_check("loss_pre", C_LC + 6);
        @(negedge clock);
        locked = 1'b0;
        @(posedge clock);                     // Ej
        @(posedge clock);                     // Ej+1
        #1;
        n_checks++;
        if (rst_out_a !== 1'b0) $display("FAIL loss_ej1: rst_out=%b required 0", rst_out_a);
        else n_pass++;
        @(posedge clock);                     // Ej+2
        #1;
        n_checks++;
        if (rst_out_a !== 1'b1 || ready_a !== 1'b0 || tick_a !== 1'b0 || tick_b !== 1'b0)
            $display("FAIL loss_ej2: rst_out=%b ready=%b tick=%b/%b required 1 0 0/0",
                     rst_out_a, ready_a, tick_a, tick_b);
        else n_pass++;
        lock_and_check("relock", C_LC + 8);
`ifdef CLK_LOCK_LOSS_CNT_EN
        n_checks++;
        if (cnt_a !== 8'd1) $display("FAIL loss_cnt_1: got %0d required 1", cnt_a);
        else n_pass++;
        for (int n = 0; n < 299; n++) begin
            wait_cnt = 0;
            while (ready_a !== 1'b1 && wait_cnt < 40) begin
                @(posedge clock);
                #1;
                wait_cnt++;
            end
            if (ready_a !== 1'b1) begin
                n_checks++;
                $display("FAIL loss_wait_ready: loss %0d ready=%b required 1", n, ready_a);
                break;
            end
            @(negedge clock);
            locked = 1'b0;
            repeat (3) @(posedge clock);
            @(negedge clock);
            locked = 1'b1;
        end
        n_checks++;
        if (cnt_a !== 8'd255) $display("FAIL loss_cnt_sat: got %0d required 255", cnt_a);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        @(negedge clock);
        locked = 1'b1;
        repeat (C_LC + 6) @(posedge clock);
        #1;
        n_checks++;
        if (ready_a !== 1'b1) $display("FAIL areset_pre: ready=%b required 1", ready_a);
        else n_pass++;
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rst_out_a !== 1'b1 || ready_a !== 1'b0 || tick_a !== 1'b0 ||
            rst_out_b !== 1'b1 || ready_b !== 1'b0 || tick_b !== 1'b0)
            $display("FAIL areset_mid: a=%b%b%b b=%b%b%b required 100 100",
                     rst_out_a, ready_a, tick_a, rst_out_b, ready_b, tick_b);
        else n_pass++;
`ifdef CLK_LOCK_LOSS_CNT_EN
        n_checks++;
        if (cnt_a !== 8'd0) $display("FAIL areset_cnt: got %0d required 0", cnt_a);
        else n_pass++;
`endif
        @(negedge clock);
        reset  = 1'b0;
        locked = 1'b0;
    endtask

    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_nco();
        test_lock_loss();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clk_reset_gen
`default_nettype wire
